// File: rtl/pe_tile_mac.sv
// Weight-stationary compute tile. It latches a TM x TN weight matrix, streams TN-wide feature vectors
// through a multiply / adder-tree / accumulate pipe, and emits one rounded, saturated word per tile.
module pe_tile_mac #(
    parameter int TM    = 4,
    parameter int TN    = 16,
    parameter int DW    = 16,
    parameter int ACC_W = 48,
    parameter int FRAC  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          top_level_state,
    input  logic [TM*TN*DW-1:0] weight,
    input  logic                wl_finish_flg,
    input  logic [7:0]          acc_len,
    input  logic                in_valid,
    input  logic [TN*DW-1:0]    in_data,
    output logic                in_ready,
    output logic                out_valid,
    output logic [TM*DW-1:0]    out_data,
    input  logic                out_ready,
    output logic                busy
);
    localparam int NG = TN / 4;
    localparam int PW = 2 * DW;
    localparam int GW = PW + 2;
    localparam int SW = PW + $clog2(TN);
    localparam logic [2:0] COMPUTE = 3'd3;
    localparam logic signed [ACC_W:0] RND_ONE = (ACC_W + 1)'(1) << (FRAC - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LATCH = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [TM*TN*DW-1:0]    w_q, w_d;
    logic [7:0]             len_q, len_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic signed [PW-1:0]   p_q [TM][TN];
    logic signed [PW-1:0]   p_d [TM][TN];
    logic signed [GW-1:0]   g_q [TM][NG];
    logic signed [GW-1:0]   g_d [TM][NG];
    logic signed [ACC_W-1:0] s3_q [TM];
    logic signed [ACC_W-1:0] s3_d [TM];
    logic signed [ACC_W-1:0] acc_q [TM];
    logic signed [ACC_W-1:0] acc_d [TM];
    logic [TM*DW-1:0]       out_q, out_d;
    logic [TM*DW-1:0]       y_all;
    logic                   hs, run_ok, pipe_empty, aborting;

    assign in_ready   = (state_q == S_RUN);
    assign out_valid  = (state_q == S_OUT);
    assign busy       = (state_q != S_IDLE);
    assign out_data   = out_q;
    assign hs         = in_valid & in_ready;
    assign run_ok     = (top_level_state == COMPUTE);
    assign pipe_empty = ~(v1_q | v2_q | v3_q);
    assign aborting   = ~run_ok & ((state_q == S_LATCH) | (state_q == S_RUN) | (state_q == S_DRAIN));

    genvar gi, gj;
    generate
        for (gi = 0; gi < TM; gi++) begin : g_row
            for (gj = 0; gj < TN; gj++) begin : g_mul
                logic signed [PW-1:0] w_ext, x_ext;
                assign w_ext = {{DW{w_q[(gi*TN+gj)*DW+DW-1]}}, w_q[(gi*TN+gj)*DW +: DW]};
                assign x_ext = {{DW{in_data[gj*DW+DW-1]}}, in_data[gj*DW +: DW]};
                assign p_d[gi][gj] = w_ext * x_ext;
            end

            for (gj = 0; gj < NG; gj++) begin : g_grp
                assign g_d[gi][gj] = GW'(p_q[gi][4*gj])   + GW'(p_q[gi][4*gj+1])
                                   + GW'(p_q[gi][4*gj+2]) + GW'(p_q[gi][4*gj+3]);
            end

            logic signed [SW-1:0] s3_sum;
            always_comb begin
                s3_sum = '0;
                for (int k = 0; k < NG; k++) begin
                    s3_sum = s3_sum + SW'(g_q[gi][k]);
                end
            end
            assign s3_d[gi] = ACC_W'(s3_sum);

            // Round half up, then clamp anything whose upper bits are not a pure sign extension.
            logic signed [ACC_W:0] rnd, shf;
            logic                  in_range;
            assign rnd      = {acc_q[gi][ACC_W-1], acc_q[gi]} + RND_ONE;
            assign shf      = rnd >>> FRAC;
            assign in_range = (shf[ACC_W:DW-1] == '0) || (shf[ACC_W:DW-1] == '1);
            assign y_all[gi*DW +: DW] = in_range ? shf[DW-1:0]
                                      : (shf[ACC_W] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}});
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        v1_d    = hs;
        v2_d    = v1_q;
        v3_d    = v2_q;
        for (int m = 0; m < TM; m++) begin
            acc_d[m] = v3_q ? acc_q[m] + s3_q[m] : acc_q[m];
        end

        case (state_q)
            S_IDLE: begin
                if (run_ok && wl_finish_flg) state_d = S_LATCH;
            end
            S_LATCH: begin
                w_d     = weight;
                len_d   = acc_len;
                cnt_d   = '0;
                for (int m = 0; m < TM; m++) acc_d[m] = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (hs) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == len_q) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pipe_empty) begin
                    out_d   = y_all;
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    for (int m = 0; m < TM; m++) acc_d[m] = '0;
                    cnt_d   = '0;
                    len_d   = acc_len;
                    state_d = run_ok ? S_RUN : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Leaving compute mid-tile throws away everything in flight; OUT is exempt.
        if (aborting) begin
            state_d = S_IDLE;
            w_d     = w_q;
            v1_d    = 1'b0;
            v2_d    = 1'b0;
            v3_d    = 1'b0;
            cnt_d   = '0;
            for (int m = 0; m < TM; m++) acc_d[m] = '0;
        end
    end

    always_ff @(posedge clk) begin
        p_q  <= p_d;
        g_q  <= g_d;
        s3_q <= s3_d;
        w_q  <= w_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            out_q   <= '0;
            for (int m = 0; m < TM; m++) acc_q[m] <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            v3_q    <= v3_d;
            out_q   <= out_d;
            acc_q   <= acc_d;
        end
    end
endmodule

// File: tb/tb_pe_tile_mac.sv
// Directed and randomised checks of pe_tile_mac against a plain-arithmetic model of one tile:
// sum of W*X over the accepted vectors, rounded half up, shifted and saturated per output channel.
module tb_pe_tile_mac;
    localparam int TM    = 4;
    localparam int TN    = 16;
    localparam int DW    = 16;
    localparam int ACC_W = 48;
    localparam int FRAC  = 8;
    localparam longint YMAX = (longint'(1) <<< (DW - 1)) - 1;
    localparam longint YMIN = -(longint'(1) <<< (DW - 1));

    logic                clk = 1'b0;
    logic                rst;
    logic [2:0]          top_level_state;
    logic [TM*TN*DW-1:0] weight;
    logic                wl_finish_flg;
    logic [7:0]          acc_len;
    logic                in_valid;
    logic [TN*DW-1:0]    in_data;
    logic                in_ready;
    logic                out_valid;
    logic [TM*DW-1:0]    out_data;
    logic                out_ready;
    logic                busy;

    pe_tile_mac #(.TM(TM), .TN(TN), .DW(DW), .ACC_W(ACC_W), .FRAC(FRAC)) dut (
        .clk             (clk),
        .rst             (rst),
        .top_level_state (top_level_state),
        .weight          (weight),
        .wl_finish_flg   (wl_finish_flg),
        .acc_len         (acc_len),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .in_ready        (in_ready),
        .out_valid       (out_valid),
        .out_data        (out_data),
        .out_ready       (out_ready),
        .busy            (busy)
    );

    initial forever #5 clk = ~clk;

    logic [DW-1:0]    wt [TM][TN];
    logic [TN*DW-1:0] vq [$];
    logic [TM*DW-1:0] exp_q [$];
    int               n_vec = 0;
    int               n_mis = 0;
    int               n_tiles = 0;
    bit               hs_seen;
    bit               out_hs_seen;

    function automatic logic [TM*TN*DW-1:0] pack_w();
        logic [TM*TN*DW-1:0] b;
        b = '0;
        for (int m = 0; m < TM; m++)
            for (int n = 0; n < TN; n++)
                b[(m*TN+n)*DW +: DW] = wt[m][n];
        return b;
    endfunction

    function automatic logic [TM*DW-1:0] model_tile();
        logic [TM*DW-1:0] y;
        logic [TN*DW-1:0] x;
        longint acc, r;
        y = '0;
        for (int m = 0; m < TM; m++) begin
            acc = 0;
            for (int v = 0; v < vq.size(); v++) begin
                x = vq[v];
                for (int n = 0; n < TN; n++)
                    acc += longint'($signed(wt[m][n])) * longint'($signed(x[n*DW +: DW]));
            end
            r = (acc + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
            if (r > YMAX) r = YMAX;
            else if (r < YMIN) r = YMIN;
            y[m*DW +: DW] = r[DW-1:0];
        end
        return y;
    endfunction

    // mode 0: small signed, 1: full range, 2: all cval, 3: small with X[0]=1
    function automatic logic [TN*DW-1:0] make_vec(input int mode, input logic [DW-1:0] cval);
        logic [TN*DW-1:0] v;
        for (int n = 0; n < TN; n++) begin
            case (mode)
                1:       v[n*DW +: DW] = DW'($urandom);
                2:       v[n*DW +: DW] = cval;
                default: v[n*DW +: DW] = DW'($urandom_range(0, 1023) - 512);
            endcase
        end
        if (mode == 3) v[DW-1:0] = DW'(1);
        return v;
    endfunction

    task automatic set_w_rand(input bit full);
        for (int m = 0; m < TM; m++)
            for (int n = 0; n < TN; n++)
                wt[m][n] = full ? DW'($urandom) : DW'($urandom_range(0, 1023) - 512);
    endtask

    task automatic set_w_const(input logic [DW-1:0] c);
        for (int m = 0; m < TM; m++)
            for (int n = 0; n < TN; n++)
                wt[m][n] = c;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic monitor();
        hs_seen     = in_valid && in_ready;
        out_hs_seen = out_valid && out_ready;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_mis++;
                $display("FAIL unexpected_out: got out_valid=1 data=0x%h, required no output", out_data);
            end else begin
                chk("out_data", out_data, exp_q[0]);
                chk("in_ready_during_out", in_ready, 0);
                if (out_ready) begin
                    $display("tile %0d: out_data=0x%h", n_tiles, out_data);
                    n_tiles++;
                    exp_q.delete(0);
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic enter_tile(input int len);
        weight          = pack_w();
        acc_len         = 8'(len);
        top_level_state = 3'd3;
        wl_finish_flg   = 1'b1;
        for (int t = 0; t < 20 && !in_ready; t++) step();
        chk("enter_in_ready", in_ready, 1);
        for (int i = 0; i < TM*TN*DW/32; i++) weight[i*32 +: 32] = $urandom;
        wl_finish_flg = 1'b0;
        acc_len       = 8'($urandom);
    endtask

    task automatic feed(input int n, input bit b2b, input int mode, input logic [DW-1:0] cval);
        bit got;
        logic [TN*DW-1:0] v;
        for (int k = 0; k < n; k++) begin
            if (!b2b) repeat ($urandom_range(0, 2)) step();
            v        = make_vec(mode, cval);
            in_data  = v;
            in_valid = 1'b1;
            got      = 1'b0;
            for (int t = 0; t < 20 && !got; t++) begin
                step();
                got = hs_seen;
            end
            chk("feed_handshake", got, 1);
            if (got) vq.push_back(v);
            in_valid = 1'b0;
            in_data  = make_vec(1, '0);
        end
    endtask

    task automatic take_output(input int stall, input int next_len, input bit stay);
        out_ready = 1'b0;
        for (int t = 0; t < 50 && !out_valid; t++) step();
        chk("out_valid_arrives", out_valid, 1);
        repeat (stall) step();
        acc_len         = 8'(next_len);
        top_level_state = stay ? 3'd3 : 3'd0;
        out_ready       = 1'b1;
        step();
        chk("out_handshake", out_hs_seen, 1);
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int len, nlen, ntiles;

        rst = 1'b1; top_level_state = 3'd0; weight = '0; wl_finish_flg = 1'b0;
        acc_len = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) step();
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_in_ready", in_ready, 0);
        chk("reset_busy", busy, 0);
        rst = 1'b0;
        step();

        // Unity weights and features: 16 * 1.0 = 16.0, plus output latency after the handshake
        set_w_const(16'h0100);
        enter_tile(0);
        exp_q.push_back({TM{16'h1000}});
        feed(1, 1'b1, 2, 16'h0100);
        vq.delete();
        lat = 1;
        while (!out_valid && lat < 50) begin
            step();
            lat++;
        end
        chk("t1_latency", lat, 5);
        take_output(0, 0, 1'b0);

        // Row-scaled weights, four back-to-back vectors
        for (int m = 0; m < TM; m++)
            for (int n = 0; n < TN; n++)
                wt[m][n] = DW'(m + 1);
        enter_tile(3);
        feed(4, 1'b1, 2, 16'h0100);
        vq.delete();
        exp_q.push_back({16'h0100, 16'h00C0, 16'h0080, 16'h0040});
        take_output(2, 0, 1'b0);

        // Positive and negative saturation
        set_w_const(16'h7FFF);
        enter_tile(255);
        feed(256, 1'b1, 2, 16'h7FFF);
        vq.delete();
        exp_q.push_back({TM{16'h7FFF}});
        take_output(1, 0, 1'b0);
        set_w_const(16'h8000);
        enter_tile(0);
        feed(1, 1'b1, 2, 16'h7FFF);
        vq.delete();
        exp_q.push_back({TM{16'h8000}});
        take_output(0, 0, 1'b0);

        // Rounding edges: acc = 0x80, 0x7F, -0x80, -0x81
        set_w_const(16'h0000);
        wt[0][0] = 16'h0080; wt[1][0] = 16'h007F; wt[2][0] = 16'hFF80; wt[3][0] = 16'hFF7F;
        enter_tile(0);
        feed(1, 1'b1, 3, '0);
        vq.delete();
        exp_q.push_back({16'hFFFF, 16'h0000, 16'h0000, 16'h0001});
        take_output(0, 0, 1'b0);

        // Output backpressure, then a following tile on the same weights
        set_w_rand(1'b0);
        enter_tile(2);
        feed(3, 1'b0, 0, '0);
        exp_q.push_back(model_tile());
        vq.delete();
        take_output(10, 1, 1'b1);
        feed(2, 1'b0, 0, '0);
        exp_q.push_back(model_tile());
        vq.delete();
        take_output(0, 0, 1'b0);

        // Abort after two of four vectors, then a clean re-entry
        set_w_rand(1'b0);
        enter_tile(3);
        feed(2, 1'b0, 0, '0);
        vq.delete();
        top_level_state = 3'd0;
        step();
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 0);
        chk("abort_out_valid", out_valid, 0);
        repeat (8) step();
        enter_tile(3);
        feed(4, 1'b0, 0, '0);
        exp_q.push_back(model_tile());
        vq.delete();
        take_output(0, 0, 1'b0);

        // Reset with the pipe full
        set_w_rand(1'b0);
        enter_tile(10);
        feed(5, 1'b1, 0, '0);
        vq.delete();
        rst = 1'b1;
        top_level_state = 3'd0;
        step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        repeat (2) step();

        // Randomised sessions with multiple tiles per weight latch
        for (int s = 0; s < 8; s++) begin
            set_w_rand(s % 3 == 2);
            len = $urandom_range(0, 6);
            enter_tile(len);
            ntiles = $urandom_range(1, 3);
            for (int t = 0; t < ntiles; t++) begin
                feed(len + 1, 1'($urandom_range(0, 1)), (s % 3 == 2) ? 1 : 0, '0);
                exp_q.push_back(model_tile());
                vq.delete();
                nlen = $urandom_range(0, 6);
                take_output($urandom_range(0, 3), nlen, t != ntiles - 1);
                len = nlen;
            end
            chk("session_idle_busy", busy, 0);
        end

        repeat (4) step();
        chk("pending_outputs", 64'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
